// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file writeback path: PPP mode codes,
// default widths and the grant encoding used by the writeback arbiter.
package regfile_pkg;

  localparam int DATA_WIDTH_DEF = 64;
  localparam int ADDR_WIDTH_DEF = 5;
  localparam int PPP_WIDTH      = 3;

  // Codes 5-7 are not listed; they travel through the arbiter untouched.
  typedef enum logic [PPP_WIDTH-1:0] {
    PPP_A = 3'b000,
    PPP_U = 3'b001,
    PPP_D = 3'b010,
    PPP_E = 3'b011,
    PPP_O = 3'b100
  } ppp_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_ALU  = 2'd1,
    GNT_LD   = 2'd2
  } grant_e;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO for load returns. Pointers wrap modulo DEPTH (power of two);
// a push into a full FIFO is accepted only when a pop happens the same cycle.
module wb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is never reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register file's single write port between the execute stage
// (valid/ready) and a queue of load returns, with bounded load starvation.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int LD_DEPTH   = 4,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  aluValid,
  output logic                  aluReady,
  input  logic [ADDR_WIDTH-1:0] aluAddr,
  input  logic [DATA_WIDTH-1:0] aluData,
  input  logic [2:0]            aluPpp,
  input  logic                  ldValid,
  input  logic [ADDR_WIDTH-1:0] ldAddr,
  input  logic [DATA_WIDTH-1:0] ldData,
  input  logic [2:0]            ldPpp,
  output logic                  ldFull,
  output logic                  ldOverflow,
  output logic                  wrEn,
  output logic [ADDR_WIDTH-1:0] wrAddr,
  output logic [DATA_WIDTH-1:0] dataIn,
  output logic [2:0]            ppp
);

  localparam int EW = ADDR_WIDTH + DATA_WIDTH + 3;
  localparam int CW = $clog2(LD_DEPTH) + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  // Handshake: the ALU beat transfers on a cycle with aluValid && aluReady.
  // aluReady drops only on a forced-load cycle; loads have no backpressure.

  logic [EW-1:0]         ld_entry;
  logic [EW-1:0]         head;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_data;
  logic [2:0]            head_ppp;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_pop;
  logic [CW-1:0]         ld_count;
  logic [SW-1:0]         starve_cnt;
  logic                  force_ld;
  grant_e                grant;

  assign ld_entry = {ldAddr, ldData, ldPpp};
  assign {head_addr, head_data, head_ppp} = head;

  wb_fifo #(
    .WIDTH (EW),
    .DEPTH (LD_DEPTH)
  ) u_ld_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (ldValid),
    .pop   (fifo_pop),
    .wdata (ld_entry),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (ld_count)
  );

  assign force_ld = (starve_cnt == SW'(STARVE_MAX));
  assign aluReady = !force_ld;
  assign ldFull   = (ld_count == CW'(LD_DEPTH));

  // No grant while reset is held, so nothing reaches the regfile during reset.
  always_comb begin
    grant = GNT_NONE;
    if (reset) begin
      if (aluValid && !force_ld) grant = GNT_ALU;
      else if (!fifo_empty)      grant = GNT_LD;
    end
  end

  assign fifo_pop = (grant == GNT_LD);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (fifo_pop || fifo_empty) begin
      starve_cnt <= '0;
    end else if (grant == GNT_ALU) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ldOverflow <= 1'b0;
    end else if (ldValid && fifo_full && !fifo_pop) begin
      ldOverflow <= 1'b1;
    end
  end

  // Address 0 is consumed like any other entry but never written.
  always_comb begin
    wrEn   = 1'b0;
    wrAddr = '0;
    dataIn = '0;
    ppp    = '0;
    case (grant)
      GNT_ALU: begin
        wrAddr = aluAddr;
        dataIn = aluData;
        ppp    = aluPpp;
        wrEn   = (aluAddr != '0);
      end
      GNT_LD: begin
        wrAddr = head_addr;
        dataIn = head_data;
        ppp    = head_ppp;
        wrEn   = (head_addr != '0);
      end
      default: begin
        wrEn = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, default 64, register data width; ADDR_WIDTH, default 5, register address width; LD_DEPTH, default 4, load-return FIFO entries; STARVE_MAX, default 4, consecutive lost cycles before load forced.
REQ-002 SHALL have port clk, input, 1, single clock, all state on rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports aluValid in 1, aluReady out 1, aluAddr in ADDR_WIDTH, aluData in DATA_WIDTH, aluPpp in 3: execute-stage writeback, valid/ready handshake.
REQ-005 SHALL have ports ldValid in 1, ldAddr in ADDR_WIDTH, ldData in DATA_WIDTH, ldPpp in 3: load/NIC return, no backpressure.
REQ-006 SHALL have ports ldFull out 1 (FIFO full, issue no new loads), ldOverflow out 1 (sticky drop error).
REQ-007 SHALL have ports wrEn out 1, wrAddr out ADDR_WIDTH, dataIn out DATA_WIDTH, ppp out 3: drive the register file's single write port directly.

Function
REQ-008 SHALL enqueue every ldValid beat into a LD_DEPTH-entry FIFO {addr, data, ppp}, same cycle, independent of arbitration.
REQ-009 SHALL, when a load is enqueued into an empty FIFO, make it eligible the following cycle (no same-cycle bypass).
REQ-010 SHALL grant ALU by default: grant ALU when aluValid=1 and force=0; else grant FIFO head when non-empty.
REQ-011 SHALL hold starveCnt, incremented each cycle FIFO non-empty and ALU granted, cleared on any FIFO pop or FIFO empty; force=1 when starveCnt==STARVE_MAX.
REQ-012 SHALL, when force=1, grant FIFO head and drive aluReady=0 for that cycle.
REQ-013 SHALL drive aluReady=1 whenever force=0 (ALU transfer completes on aluValid&aluReady).
REQ-014 SHALL drive wrEn/wrAddr/dataIn/ppp combinationally from the granted source; wrEn=0 and other outputs 0 when no grant.
REQ-015 SHALL drive wrEn=0 for a granted entry with addr 0 while still consuming it (ALU handshake completes, FIFO pops).
REQ-016 SHALL pass ppp codes unchanged; codes 5-7 forwarded as-is (regfile ignores them).
REQ-017 SHALL accept enqueue when FIFO full and a pop occurs the same cycle; count unchanged.
REQ-018 SHALL drop ldValid beat when full with no pop that cycle, set ldOverflow=1 until reset; FIFO contents unchanged.
REQ-019 SHALL assert ldFull=1 when count==LD_DEPTH, registered from count.
REQ-020 SHALL make FIFO pointers wrap modulo LD_DEPTH; LD_DEPTH a power of two, count width clog2(LD_DEPTH)+1.
REQ-021 SHALL preserve program order per source; ALU and load writes to the same address in consecutive grants resolve as last-granted-wins.

Reset
REQ-022 SHALL, on reset=0, asynchronously clear FIFO pointers, count, starveCnt, ldOverflow; outputs wrEn=0, ldFull=0, ldOverflow=0, aluReady=1 while held and after release.
REQ-023 SHALL discard FIFO contents on reset mid-operation; data storage not cleared.

Structure
REQ-024 SHALL import shared package regfile_pkg: PPP mode constants (A=000, U=001, D=010, E=011, O=100), DATA_WIDTH, ADDR_WIDTH defaults.
REQ-025 SHALL instantiate one sub-module wb_fifo (parameterised sync FIFO with push, pop, full, empty, count); arbitration and starvation logic in top.

Verification
REQ-026 SHALL cover: ALU-only stream addr 1..5, data 0x11..0x55, ppp A -> wrEn=1 each cycle, zero latency, aluReady=1 throughout.
REQ-027 SHALL cover: one load addr 7 data 0xAA while ALU idle -> wrEn addr 7 exactly one cycle after ldValid.
REQ-028 SHALL cover: ALU valid every cycle plus one load -> load written on 5th cycle after enqueue (STARVE_MAX=4), aluReady=0 that cycle only.
REQ-029 SHALL cover: 5 back-to-back loads with ALU busy -> ldFull=1 after 4th, 5th dropped, ldOverflow=1; then 4 entries drain in order.
REQ-030 SHALL cover: full FIFO, forced pop and ldValid same cycle -> new beat accepted, ldOverflow stays 0.
REQ-031 SHALL cover: reset=0 asserted with 3 queued loads mid-cycle -> wrEn=0 immediately, after release no stale writes, ldFull=0.
